// File: rtl/riscv16_pkg.sv
// riscv16_pkg: shared constants for the 16-bit lab CPU.
// Holds the opcode, ALU fn and branch condition codes, the instruction
// field positions and the FSM state type.
package riscv16_pkg;

    // Opcodes, taken from instruction bits [15:12]
    localparam logic [3:0] OP_ALU  = 4'b0000;
    localparam logic [3:0] OP_LDR  = 4'b0001;
    localparam logic [3:0] OP_STR  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_MOV  = 4'b0101;
    localparam logic [3:0] OP_BCC  = 4'b1100;
    localparam logic [3:0] OP_SYS  = 4'b1110;

    // ALU function codes, taken from bits [1:0]
    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_AND = 2'b01;
    localparam logic [1:0] FN_SUB = 2'b10;
    localparam logic [1:0] FN_OR  = 2'b11;

    // System sub-functions of OP_SYS, also taken from bits [1:0]
    localparam logic [1:0] SYS_OUT = 2'b00;
    localparam logic [1:0] SYS_HLT = 2'b01;

    // Branch condition codes, taken from bits [11:8]
    localparam logic [3:0] CC_AL = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_EQ = 4'b0100;

    // Instruction field positions
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int SEL_BIT = 11;
    localparam int RD_HI   = 10;
    localparam int RD_LO   = 8;
    localparam int RA_HI   = 7;
    localparam int RA_LO   = 5;
    localparam int RB_HI   = 4;
    localparam int RB_LO   = 2;
    localparam int FN_HI   = 1;
    localparam int FN_LO   = 0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    // ADD and SUB are the only ALU functions that produce a carry flag
    function automatic logic is_arith(input logic [1:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB);
    endfunction

endpackage

// File: rtl/riscv16_if.sv
// riscv16_if: program load port and result outputs of the lab CPU.
// The testbench or board logic is the master; the core is the slave.
interface riscv16_if;
    logic        ext_we;
    logic [15:0] ext_data;
    logic [15:0] OutR;
    logic        done;

    modport master (output ext_we, output ext_data, input OutR, input done);
    modport slave  (input ext_we, input ext_data, output OutR, output done);
endinterface

// File: rtl/riscv16_alu.sv
// riscv16_alu: combinational ALU (ADD, SUB and, optionally, AND/OR).
// Optional feature macro: RISCV16_LOGIC_OPS_EN enables the AND/OR paths.
// Without it fn 01/11 return zero; the core never writes those results back.
module riscv16_alu
    import riscv16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  fn,
    output logic [15:0] result,
    output logic        z,
    output logic        c,
    output logic        n
);

    logic [16:0] wide;

    // 17-bit datapath so that bit 16 is the carry out (SUB as a + ~b + 1)
    always_comb begin
        wide = '0;
        case (fn)
            FN_ADD:  wide = {1'b0, a} + {1'b0, b};
            FN_SUB:  wide = {1'b0, a} + {1'b0, ~b} + 17'd1;
`ifdef RISCV16_LOGIC_OPS_EN
            FN_AND:  wide = {1'b0, a & b};
            FN_OR:   wide = {1'b0, a | b};
`endif
            default: wide = '0;
        endcase
    end

    assign result = wide[15:0];
    assign c      = wide[16];
    assign z      = (wide[15:0] == 16'h0000);
    assign n      = wide[15];

endmodule

// File: rtl/riscv_16bit.sv
// riscv_16bit: two-cycle (FETCH/EXEC) 16-bit register CPU with an
// 8x16 register file and a unified program/data memory.
// Optional feature macro: RISCV16_LOGIC_OPS_EN (ALU AND/OR instructions).
module riscv_16bit
    import riscv16_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic      clk,
    input  logic      PC_rst,
    riscv16_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef RISCV16_LOGIC_OPS_EN
    localparam logic LOGIC_OPS = 1'b1;
`else
    localparam logic LOGIC_OPS = 1'b0;
`endif

    logic [15:0]       mem  [DEPTH];
    logic [15:0]       regs [8];
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] lp;
    logic [15:0]       ir;
    logic              flag_z;
    logic              flag_c;
    logic              flag_n;
    logic [15:0]       out_r;
    logic              done_r;

    logic [3:0]        op;
    logic              sel;
    logic [2:0]        rd;
    logic [2:0]        ra;
    logic [2:0]        rb;
    logic [1:0]        fn;
    logic [3:0]        cond;
    logic [7:0]        imm8;
    logic [4:0]        imm5;

    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_branch;

    logic [15:0]       alu_a;
    logic [15:0]       alu_b;
    logic [1:0]        alu_fn;
    logic [15:0]       alu_result;
    logic              alu_z;
    logic              alu_c;
    logic              alu_n;
    logic              alu_op_ok;
    logic              taken;

    assign op   = ir[OP_HI:OP_LO];
    assign sel  = ir[SEL_BIT];
    assign rd   = ir[RD_HI:RD_LO];
    assign ra   = ir[RA_HI:RA_LO];
    assign rb   = ir[RB_HI:RB_LO];
    assign fn   = ir[FN_HI:FN_LO];
    assign cond = ir[SEL_BIT:RD_LO];
    assign imm8 = ir[7:0];
    assign imm5 = ir[4:0];

    // Effective address and branch target both wrap at the memory size
    assign ea        = ADDR_W'(regs[ra] + {11'b0, imm5});
    assign pc_plus1  = pc + ADDR_W'(1);
    assign pc_branch = pc_plus1 + ADDR_W'({{8{imm8[7]}}, imm8});

    // Logic ops are dropped entirely (no writeback, no flags) when disabled
    assign alu_op_ok = is_arith(fn) || LOGIC_OPS;

    // Pick ALU operands: register ALU ops, ADDI (add imm5) and CMP (subtract)
    always_comb begin
        alu_a  = regs[ra];
        alu_b  = regs[rb];
        alu_fn = fn;
        if (op == OP_ADDI) begin
            if (sel) begin
                alu_b  = {11'b0, imm5};
                alu_fn = FN_ADD;
            end else begin
                alu_fn = FN_SUB;
            end
        end
    end

    // Evaluate the branch condition against the current flags
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_AL:   taken = 1'b1;
            CC_NE:   taken = !flag_z;
            CC_CS:   taken = flag_c;
            CC_CC:   taken = !flag_c;
            CC_EQ:   taken = flag_z;
            default: taken = 1'b0;
        endcase
    end

    riscv16_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fn     (alu_fn),
        .result (alu_result),
        .z      (alu_z),
        .c      (alu_c),
        .n      (alu_n)
    );

    // Memory: the load port wins over a store; contents survive reset
    always_ff @(posedge clk) begin
        if (bus.ext_we) begin
            mem[lp] <= bus.ext_data;
        end else if (state == EXEC && op == OP_STR) begin
            mem[ea] <= regs[rd];
        end
    end

    // Core FSM: loading stalls everything, otherwise FETCH -> EXEC -> FETCH/HALT
    always_ff @(posedge clk or negedge PC_rst) begin
        if (!PC_rst) begin
            state  <= FETCH;
            pc     <= '0;
            lp     <= '0;
            ir     <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
            out_r  <= '0;
            done_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.ext_we) begin
            lp <= lp + ADDR_W'(1);
        end else begin
            case (state)
                FETCH: begin
                    ir    <= mem[pc];
                    state <= EXEC;
                end
                EXEC: begin
                    pc    <= pc_plus1;
                    state <= FETCH;
                    case (op)
                        OP_ALU: begin
                            if (sel) begin
                                regs[rd] <= {8'h00, imm8};
                            end else if (alu_op_ok) begin
                                regs[rd] <= alu_result;
                                flag_z   <= alu_z;
                                flag_n   <= alu_n;
                                if (is_arith(fn)) begin
                                    flag_c <= alu_c;
                                end
                            end
                        end
                        OP_LDR: regs[rd] <= mem[ea];
                        OP_ADDI: begin
                            if (sel) begin
                                regs[rd] <= alu_result;
                            end
                            flag_z <= alu_z;
                            flag_c <= alu_c;
                            flag_n <= alu_n;
                        end
                        OP_MOV: regs[rd] <= regs[ra];
                        OP_BCC: begin
                            if (taken) begin
                                pc <= pc_branch;
                            end
                        end
                        OP_SYS: begin
                            if (fn == SYS_OUT) begin
                                out_r <= regs[ra];
                            end else if (fn == SYS_HLT) begin
                                done_r <= 1'b1;
                                state  <= HALT;
                            end
                        end
                        default: ;
                    endcase
                end
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.OutR = out_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_riscv_16bit.sv
// tb_riscv_16bit: directed programs plus random straight-line/forward-branch
// programs, checked against an instruction-level model of the CPU.
// Optional feature macro: RISCV16_LOGIC_OPS_EN (the model follows it too).
module tb_riscv_16bit;

    logic clk = 1'b0;
    logic PC_rst;
    riscv16_if bus ();

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] image [256];

    always #5 clk = ~clk;

    riscv_16bit #(.ADDR_W(8)) dut (
        .clk    (clk),
        .PC_rst (PC_rst),
        .bus    (bus)
    );

    task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Instruction-level model: runs the image until HLT, returns OutR and cycle count
    task automatic run_model(output logic [15:0] out_exp, output int cycles_exp);
        int m [256];
        int r [8];
        int pc, ir, op, rd, ra, rb, fn, a, b, res, steps, addr, off;
        bit z, c, n, halted, tk;
        for (int i = 0; i < 256; i++) m[i] = int'(image[i]);
        for (int i = 0; i < 8; i++) r[i] = 0;
        pc = 0; z = 0; c = 0; n = 0; halted = 0; steps = 0; out_exp = 16'h0000;
        while (!halted && steps < 1000) begin
            ir = m[pc];
            op = (ir >> 12) & 15; rd = (ir >> 8) & 7; ra = (ir >> 5) & 7;
            rb = (ir >> 2) & 7;   fn = ir & 3;
            steps++;
            pc = (pc + 1) % 256;
            case (op)
                0: begin
                    if ((ir >> 11) & 1) r[rd] = ir & 255;
                    else begin
                        a = r[ra]; b = r[rb];
                        if (fn == 0 || fn == 2) begin
                            if (fn == 0) begin res = (a + b) % 65536; c = (a + b) > 65535; end
                            else begin res = (a - b + 65536) % 65536; c = (a >= b); end
                            r[rd] = res; z = (res == 0); n = res >= 32768;
                        end
`ifdef RISCV16_LOGIC_OPS_EN
                        else begin
                            res = (fn == 1) ? (a & b) : (a | b);
                            r[rd] = res; z = (res == 0); n = res >= 32768;
                        end
`endif
                    end
                end
                1: r[rd] = m[(r[ra] + (ir & 31)) % 256];
                2: m[(r[ra] + (ir & 31)) % 256] = r[rd];
                3: begin
                    a = r[ra];
                    if ((ir >> 11) & 1) begin
                        b = ir & 31; res = (a + b) % 65536; c = (a + b) > 65535; r[rd] = res;
                    end else begin
                        b = r[rb]; res = (a - b + 65536) % 65536; c = (a >= b);
                    end
                    z = (res == 0); n = res >= 32768;
                end
                5: r[rd] = r[ra];
                12: begin
                    case ((ir >> 8) & 15)
                        0: tk = 1;
                        1: tk = !z;
                        2: tk = c;
                        3: tk = !c;
                        4: tk = z;
                        default: tk = 0;
                    endcase
                    off = ir & 255;
                    if (off >= 128) off = off - 256;
                    if (tk) pc = (pc + off + 256) % 256;
                end
                14: begin
                    if (fn == 0) out_exp = 16'(r[ra]);
                    else if (fn == 1) halted = 1;
                end
                default: ;
            endcase
        end
        cycles_exp = 2 * steps;
    endtask

    task automatic fill_data(input int from);
        for (int i = from; i < 256; i++) image[i] = 16'($urandom);
    endtask

    task automatic load_image();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bus.ext_we   = 1'b1;
            bus.ext_data = image[i];
        end
        @(negedge clk);
        bus.ext_we = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        PC_rst = 1'b0;
        @(negedge clk);
        PC_rst = 1'b1;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done) break;
        end
    endtask

    // Load the image, restart from 0 and check OutR, done and the cycle count
    task automatic apply_stimulus(input string tag, input bit fixed, input logic [15:0] fixed_out);
        logic [15:0] model_out;
        int model_cyc, edges;
        run_model(model_out, model_cyc);
        load_image();
        pulse_reset();
        wait_done(edges);
        check_output({tag, "_done"}, {15'b0, bus.done}, 16'h0001);
        check_output({tag, "_outr"}, bus.OutR, fixed ? fixed_out : model_out);
        check_output({tag, "_cycles"}, 16'(edges), 16'(model_cyc));
    endtask

    function automatic logic [15:0] rand_instr(input int idx, input int hlt_idx);
        logic [15:0] w;
        int kind, rd, ra, rb, maxoff;
        kind = int'($urandom_range(0, 9));
        rd = int'($urandom_range(0, 6));
        ra = int'($urandom_range(0, 7));
        rb = int'($urandom_range(0, 7));
        case (kind)
            0: w = 16'h0800 | 16'(rd << 8) | 16'($urandom_range(0, 255));
            1: w = 16'(rd << 8) | 16'(ra << 5) | 16'(rb << 2) | 16'($urandom_range(0, 3));
            2: w = 16'h3800 | 16'(rd << 8) | 16'(ra << 5) | 16'($urandom_range(0, 31));
            3: w = 16'h3000 | 16'(ra << 5) | 16'(rb << 2);
            4: w = 16'h5000 | 16'(rd << 8) | 16'(ra << 5);
            5: w = 16'h10E0 | 16'($urandom_range(0, 1) << 11) | 16'(rd << 8) | 16'($urandom_range(0, 31));
            6: w = 16'h20E0 | 16'(ra << 8) | 16'($urandom_range(0, 31));
            7: begin
                maxoff = hlt_idx - idx - 1;
                if (maxoff > 2) maxoff = 2;
                w = 16'hC000 | 16'($urandom_range(0, 4) << 8) | 16'($urandom_range(0, maxoff));
            end
            8: w = 16'hE000 | 16'(ra << 5);
            default: w = 16'h4000 | 16'($urandom_range(0, 4095));
        endcase
        return w;
    endfunction

    initial begin
        int edges;
        PC_rst       = 1'b0;
        bus.ext_we   = 1'b0;
        bus.ext_data = 16'h0000;

        // Reset held for 9 cycles
        repeat (9) @(posedge clk);
        #1;
        check_output("reset_outr", bus.OutR, 16'h0000);
        check_output("reset_done", {15'b0, bus.done}, 16'h0000);
        @(negedge clk);
        PC_rst = 1'b1;

        // Load and add
        fill_data(5);
        image[0] = 16'h0805; image[1] = 16'h0907; image[2] = 16'h0204;
        image[3] = 16'hE040; image[4] = 16'hE001;
        apply_stimulus("add", 1'b1, 16'h000C);
        check_output("add_edge10", 16'(edges + 10), 16'(edges + 10));

        // Memory round trip
        fill_data(6);
        image[0] = 16'h0FC8; image[1] = 16'h0955; image[2] = 16'h21E0;
        image[3] = 16'h12E0; image[4] = 16'hE040; image[5] = 16'hE001;
        apply_stimulus("mem", 1'b1, 16'h0055);

        // Borrow flag: BCS not taken
        fill_data(6);
        image[0] = 16'h0803; image[1] = 16'h0905; image[2] = 16'h0206;
        image[3] = 16'hC201; image[4] = 16'hE040; image[5] = 16'hE001;
        apply_stimulus("borrow", 1'b1, 16'hFFFE);

        // Counting loop
        fill_data(7);
        image[0] = 16'h0800; image[1] = 16'h0B0A; image[2] = 16'h3801;
        image[3] = 16'h300C; image[4] = 16'hC1FD; image[5] = 16'hE000;
        image[6] = 16'hE001;
        apply_stimulus("loop", 1'b1, 16'h000A);

        // Reset mid-cycle after halt, then mid-loop, then rerun to completion
        @(negedge clk);
        #2;
        PC_rst = 1'b0;
        #1;
        check_output("async_outr", bus.OutR, 16'h0000);
        check_output("async_done", {15'b0, bus.done}, 16'h0000);
        @(negedge clk);
        PC_rst = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        PC_rst = 1'b0;
        #1;
        check_output("midrun_done", {15'b0, bus.done}, 16'h0000);
        check_output("midrun_outr", bus.OutR, 16'h0000);
        @(negedge clk);
        PC_rst = 1'b1;
        wait_done(edges);
        check_output("rerun_outr", bus.OutR, 16'h000A);
        check_output("rerun_cycles", 16'(edges), 16'd68);

        // Random programs: R7 points at a data window, forward branches only
        for (int t = 0; t < 10; t++) begin
            fill_data(17);
            image[0] = 16'h0FC8;
            for (int i = 1; i < 15; i++) image[i] = rand_instr(i, 16);
            image[15] = 16'hE000 | 16'($urandom_range(0, 7) << 5);
            image[16] = 16'hE001;
            apply_stimulus($sformatf("rand%0d", t), 1'b0, 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
